// File: rtl/line_buffer_ctrl_pkg.sv
// Shared definitions for the line-buffer sequencer and the window blocks that
// consume its coordinates: FSM state encoding and counter width helpers.
package line_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_CLEAR = 2'd3
  } lbc_state_t;

  // Column counter width; a one-pixel line still needs a 1-bit counter.
  function automatic int x_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

  // Row counter width; same floor of one bit.
  function automatic int y_w(input int frame_lines);
    return (frame_lines > 1) ? $clog2(frame_lines) : 1;
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_win_coord_tracker.sv
// Window-centre coordinate tracker: advances a raster (x,y) position on every
// valid window and derives the frame-edge flags used by padding logic.
module win_coord_tracker
  import line_buffer_ctrl_pkg::*;
#(
  parameter int LINE_WORDS  = 10,
  parameter int FRAME_LINES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clr,
  input  logic                          i_win_valid,
  output logic [x_w(LINE_WORDS)-1:0]    o_win_x,
  output logic [y_w(FRAME_LINES)-1:0]   o_win_y,
  output logic                          o_bdr_top,
  output logic                          o_bdr_bot,
  output logic                          o_bdr_left,
  output logic                          o_bdr_right
);

  localparam int X_W = x_w(LINE_WORDS);
  localparam int Y_W = y_w(FRAME_LINES);
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_WORDS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_LINES - 1);

  logic [X_W-1:0] r_out_x;
  logic [Y_W-1:0] r_out_y;

  // Raster position of the current window; moves on after each valid window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_x <= '0;
      r_out_y <= '0;
    end else if (i_clr) begin
      r_out_x <= '0;
      r_out_y <= '0;
    end else if (i_win_valid) begin
      if (r_out_x == X_LAST) begin
        r_out_x <= '0;
        r_out_y <= (r_out_y == Y_LAST) ? '0 : r_out_y + 1'b1;
      end else begin
        r_out_x <= r_out_x + 1'b1;
      end
    end
  end

  assign o_win_x     = r_out_x;
  assign o_win_y     = r_out_y;
  assign o_bdr_top   = i_win_valid && (r_out_y == '0);
  assign o_bdr_bot   = i_win_valid && (r_out_y == Y_LAST);
  assign o_bdr_left  = i_win_valid && (r_out_x == '0);
  assign o_bdr_right = i_win_valid && (r_out_x == X_LAST);

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequencer for the 2-bank line buffer: writes the incoming raster frame,
// flushes one zero line so the last row's windows emerge, clears the buffer
// between frames and tags buffer outputs with window-centre coordinates.
module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_WORDS  = 10,
  parameter int FRAME_LINES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_sof,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic                          lb_en,
  output logic [DATA_WIDTH-1:0]         lb_din,
  output logic                          lb_rst,
  input  logic                          lb_valid,
  output logic [x_w(LINE_WORDS)-1:0]    win_x,
  output logic [y_w(FRAME_LINES)-1:0]   win_y,
  output logic                          win_valid,
  output logic                          bdr_top,
  output logic                          bdr_bot,
  output logic                          bdr_left,
  output logic                          bdr_right,
  output logic                          frame_done,
  output logic                          sof_err
);

  localparam int X_W = x_w(LINE_WORDS);
  localparam int Y_W = y_w(FRAME_LINES);
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_WORDS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_LINES - 1);

  lbc_state_t     r_state, w_next;
  logic [X_W-1:0] r_in_x;
  logic [Y_W-1:0] r_in_y;
  logic           r_lb_rst, r_frame_done, r_sof_err;
  logic           w_wr, w_abort, w_flush_end, w_last_px, w_active;

  assign w_last_px = (r_in_x == X_LAST) && (r_in_y == Y_LAST);

  // Next state, handshake and buffer write controls.
  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    w_wr        = 1'b0;
    w_abort     = 1'b0;
    w_flush_end = 1'b0;
    lb_en       = 1'b0;
    lb_din      = '0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_sof) begin
          w_wr   = 1'b1;
          lb_din = in_data;
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        in_ready = 1'b1;
        lb_din   = in_data;
        if (in_valid) begin
          // An SOF anywhere but the first pixel position aborts the frame.
          if (in_sof && ((r_in_x != '0) || (r_in_y != '0))) begin
            w_abort = 1'b1;
            w_next  = ST_CLEAR;
          end else begin
            w_wr = 1'b1;
            if (w_last_px) w_next = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        lb_en = 1'b1;
        if (r_in_x == X_LAST) begin
          w_flush_end = 1'b1;
          w_next      = ST_CLEAR;
        end
      end
      ST_CLEAR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (w_wr) lb_en = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Input raster counters; in_x doubles as the flush column counter since it
  // has wrapped to zero when the last pixel of the frame is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_x <= '0;
      r_in_y <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_in_x <= '0;
      r_in_y <= '0;
    end else if (w_wr || (r_state == ST_FLUSH)) begin
      if (r_in_x == X_LAST) begin
        r_in_x <= '0;
        if (w_wr) r_in_y <= (r_in_y == Y_LAST) ? '0 : r_in_y + 1'b1;
      end else begin
        r_in_x <= r_in_x + 1'b1;
      end
    end
  end

  // Registered one-cycle pulses, all coincident with the CLEAR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lb_rst     <= 1'b0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_lb_rst     <= (w_next == ST_CLEAR);
      r_frame_done <= w_flush_end;
      r_sof_err    <= w_abort;
    end
  end

  assign lb_rst     = r_lb_rst;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;

  assign w_active  = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign win_valid = lb_valid && w_active;

  win_coord_tracker #(
    .LINE_WORDS  (LINE_WORDS),
    .FRAME_LINES (FRAME_LINES)
  ) u_trk (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (r_state == ST_CLEAR),
    .i_win_valid (win_valid),
    .o_win_x     (win_x),
    .o_win_y     (win_y),
    .o_bdr_top   (bdr_top),
    .o_bdr_bot   (bdr_bot),
    .o_bdr_left  (bdr_left),
    .o_bdr_right (bdr_right)
  );

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl with a simple line-buffer model producing
// dout_padded_valid on every write once one full line has been stored.
module tb_line_buffer_ctrl;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int FL = 3;
  localparam int N  = LW * FL;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_sof;
  logic [DW-1:0] in_data;
  logic          in_ready, lb_en, lb_rst, lb_valid;
  logic [DW-1:0] lb_din;
  logic [1:0]    win_x;
  logic [1:0]    win_y;
  logic          win_valid, bdr_top, bdr_bot, bdr_left, bdr_right;
  logic          frame_done, sof_err;

  always #5 clk = ~clk;

  line_buffer_ctrl #(.DATA_WIDTH(DW), .LINE_WORDS(LW), .FRAME_LINES(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_ready(in_ready), .lb_en(lb_en), .lb_din(lb_din), .lb_rst(lb_rst),
    .lb_valid(lb_valid), .win_x(win_x), .win_y(win_y), .win_valid(win_valid),
    .bdr_top(bdr_top), .bdr_bot(bdr_bot), .bdr_left(bdr_left), .bdr_right(bdr_right),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  // Line buffer model: counts stored words since its last clear.
  int   lb_cnt;
  logic noise;
  always @(posedge clk or posedge rst) begin
    if (rst)         lb_cnt <= 0;
    else if (lb_rst) lb_cnt <= 0;
    else if (lb_en)  lb_cnt <= lb_cnt + 1;
  end
  assign lb_valid = (lb_en && (lb_cnt >= LW)) || noise;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_din[$];
  int            exp_win[$];
  int n_done = 0, n_err = 0, n_rst = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: every write and every window is matched against the expected streams.
  always @(negedge clk) begin : mon
    int k;
    if (!rst) begin
      if (lb_en) begin
        if (exp_din.size() == 0) fail_now("lb_en", $sformatf("unexpected write of %0d", lb_din));
        else chk("lb_din", lb_din, exp_din.pop_front());
      end
      if (in_ready && !in_valid) chk("lb_en_on_stall", lb_en, 0);
      if (win_valid) begin
        if (exp_win.size() == 0) fail_now("win_valid", $sformatf("unexpected window at (%0d,%0d)", win_x, win_y));
        else begin
          k = exp_win.pop_front();
          chk("win_x", win_x, k % LW);
          chk("win_y", win_y, k / LW);
          chk("bdr_top", bdr_top, (k / LW) == 0);
          chk("bdr_bot", bdr_bot, (k / LW) == FL - 1);
          chk("bdr_left", bdr_left, (k % LW) == 0);
          chk("bdr_right", bdr_right, (k % LW) == LW - 1);
        end
      end else begin
        chk("bdr_gated", {bdr_top, bdr_bot, bdr_left, bdr_right}, 0);
      end
      n_done += frame_done;
      n_err  += sof_err;
      n_rst  += lb_rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel and hold it until accepted; reports cycles spent waiting.
  task automatic send(input logic [DW-1:0] d, input logic sof, output int waited);
    bit ok = 0;
    in_valid = 1'b1; in_data = d; in_sof = sof; waited = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      waited++;
      @(posedge clk); #1;
    end
    if (!ok) fail_now("in_ready_timeout", "pixel never accepted");
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_data = DW'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) fail_now("idle_timeout", "in_ready never returned");
    tick(); tick();
  endtask

  // One frame: optional pre-SOF garbage, stalls, optional abort at pixel abort_at.
  task automatic run_frame(input int abort_at, input int stall_pct, input int garbage,
                           input bit b2b, output int sof_wait);
    logic [DW-1:0] px[N];
    int cnt, nwin, w;
    sof_wait = 0;
    for (int i = 0; i < N; i++) px[i] = DW'($urandom);
    if (garbage > 0) begin
      noise = 1'b1;
      for (int g = 0; g < garbage; g++) begin
        in_valid = 1'b1; in_sof = 1'b0; in_data = DW'($urandom_range(1, 255));
        tick();
      end
      noise = 1'b0; in_valid = 1'b0;
    end
    cnt  = (abort_at < 0) ? N : abort_at;
    nwin = (abort_at < 0) ? N : ((abort_at > LW) ? abort_at - LW : 0);
    for (int i = 0; i < cnt; i++) exp_din.push_back(px[i]);
    if (abort_at < 0) for (int i = 0; i < LW; i++) exp_din.push_back('0);
    for (int k = 0; k < nwin; k++) exp_win.push_back(k);
    for (int i = 0; i < N; i++) begin
      if (i > 0 && $urandom_range(99) < stall_pct) begin
        in_valid = 1'b0; tick();
      end
      if (i == abort_at) begin
        send(px[i], 1'b1, w);
        break;
      end
      send(px[i], i == 0, w);
      if (i == 0) sof_wait = w;
    end
    if (!b2b) wait_idle();
  endtask

  typedef struct {
    int abort_at;
    int stall_pct;
    int garbage;
    bit b2b;
    int exp_wait;
    int exp_done;
    int exp_err;
    int exp_rst;
    bit check_evt;
  } scen_t;

  scen_t tbl[10];
  int b_done, b_err, b_rst, sw, ab;

  task automatic snap();
    b_done = n_done; b_err = n_err; b_rst = n_rst;
  endtask

  task automatic check_events(input string tag, input int d, input int e, input int r);
    chk({tag, "_frame_done"}, n_done - b_done, d);
    chk({tag, "_sof_err"}, n_err - b_err, e);
    chk({tag, "_lb_rst"}, n_rst - b_rst, r);
    chk({tag, "_din_left"}, exp_din.size(), 0);
    chk({tag, "_win_left"}, exp_win.size(), 0);
    snap();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{-1,   0, 0, 1'b0, 0, 1, 0, 1, 1'b1};  // basic continuous frame
    tbl[1] = '{-1, 100, 0, 1'b0, 0, 1, 0, 1, 1'b1};  // alternating stalls
    tbl[2] = '{ 6,   0, 0, 1'b0, 0, 0, 1, 1, 1'b1};  // mid-frame SOF at pixel 6
    tbl[3] = '{-1,   0, 0, 1'b0, 0, 1, 0, 1, 1'b1};  // clean frame after abort
    tbl[4] = '{-1,   0, 3, 1'b0, 0, 1, 0, 1, 1'b1};  // pre-SOF garbage
    tbl[5] = '{-1,   0, 0, 1'b1, 0, 0, 0, 0, 1'b0};  // back-to-back, first
    tbl[6] = '{-1,   0, 0, 1'b0, 5, 2, 0, 2, 1'b1};  // back-to-back, second
    tbl[7] = '{N-1, 30, 0, 1'b0, 0, 0, 1, 1, 1'b1};  // SOF on the last pixel slot
    tbl[8] = '{ 1,   0, 0, 1'b0, 0, 0, 1, 1, 1'b1};  // SOF on the second pixel
    tbl[9] = '{-1,  40, 0, 1'b0, 0, 1, 0, 1, 1'b1};  // random stalls

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; noise = 1'b0;
    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_lb_en", lb_en, 0);
    chk("reset_lb_din", lb_din, 0);
    chk("reset_lb_rst", lb_rst, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_sof_err", sof_err, 0);
    chk("reset_win_xy", {win_x, win_y}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    snap();

    for (int s = 0; s < 10; s++) begin
      run_frame(tbl[s].abort_at, tbl[s].stall_pct, tbl[s].garbage, tbl[s].b2b, sw);
      chk($sformatf("s%0d_sof_wait", s), sw, tbl[s].exp_wait);
      if (tbl[s].check_evt)
        check_events($sformatf("s%0d", s), tbl[s].exp_done, tbl[s].exp_err, tbl[s].exp_rst);
    end

    // Reset asserted part-way through FLUSH, then a normal frame.
    run_frame(-1, 0, 0, 1'b1, sw);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_flush_lb_en", lb_en, 0);
    chk("rst_flush_lb_din", lb_din, 0);
    chk("rst_flush_in_ready", in_ready, 1);
    chk("rst_flush_pulses", {lb_rst, frame_done, sof_err}, 0);
    chk("rst_flush_win", {win_valid, win_x, win_y}, 0);
    exp_din.delete();
    exp_win.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check_events("rst_flush", 0, 0, 0);
    run_frame(-1, 20, 0, 1'b0, sw);
    chk("post_rst_sof_wait", sw, 0);
    check_events("post_rst", 1, 0, 1);

    // Randomized frames against the model.
    for (int r = 0; r < 8; r++) begin
      ab = ($urandom_range(2) == 0) ? int'($urandom_range(1, N - 1)) : -1;
      run_frame(ab, $urandom_range(60), $urandom_range(2), 1'b0, sw);
      check_events($sformatf("rnd%0d", r), (ab < 0) ? 1 : 0, (ab < 0) ? 0 : 1, 1);
    end

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Sequencer for the 2-bank line buffer feeding the 3x3 window datapath. It accepts a raster pixel stream with start-of-frame and drives the buffer's enable and data, then flushes one zero line after the last input line so the final row's windows emerge. It clears the buffer between frames and annotates each buffer output with window-centre coordinates and border flags for downstream padding logic.

Parameters:
DATA_WIDTH, 8, pixel width
LINE_WORDS, 10, pixels per line; must equal the line buffer's LINE_WORDS
FRAME_LINES, 8, lines per frame (>=2)

Ports:
clk  in  1  single clock domain
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input pixel present
in_sof  in  1  marks the first pixel of a frame; qualified by in_valid
in_data  in  DATA_WIDTH  input pixel
in_ready  out  1  pixel accepted when in_valid && in_ready
lb_en  out  1  line buffer en
lb_din  out  DATA_WIDTH  line buffer din
lb_rst  out  1  one-cycle registered clear pulse; the top level ORs it with rst into the buffer's rst
lb_valid  in  1  line buffer dout_padded_valid
win_x  out  $clog2(LINE_WORDS)  centre column of the current window
win_y  out  $clog2(FRAME_LINES)  centre row of the current window
win_valid  out  1  equals lb_valid while in RUN/FLUSH
bdr_top, bdr_bot, bdr_left, bdr_right  out  1 each  window centre is on that frame edge (valid with win_valid)
frame_done  out  1  one-cycle pulse after a frame completes normally
sof_err  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset (async): state IDLE. All counters, lb_en, lb_rst, frame_done and sof_err are 0; lb_din = 0. in_ready = 1 in IDLE.
- States: IDLE, RUN, FLUSH, CLEAR (registered FSM). Input counters are in_x and in_y; output counters are out_x and out_y.
- IDLE: in_ready = 1 and lb_en = 0.
  - in_valid && !in_sof: the pixel is dropped; no other effect.
  - in_valid && in_sof: the pixel is accepted and written (lb_en = 1 in the same cycle). in_x becomes 1 and the state moves to RUN.
- RUN: in_ready = 1, lb_en = in_valid, lb_din = in_data (combinational pass-through, so the buffer write occurs in the accept cycle).
  - A stall (in_valid = 0) gives lb_en = 0; the buffer and all counters hold.
  - in_x wraps at LINE_WORDS-1 and increments in_y.
  - On accepting pixel (LINE_WORDS-1, FRAME_LINES-1), go to FLUSH with the flush counter at 0.
- Mid-frame SOF: in_sof with in_valid in RUN at any in_x/in_y other than (0,0) aborts the frame. The pixel is not written (lb_en = 0), sof_err pulses next cycle, and the state goes to CLEAR with no flush and no frame_done. That SOF pixel is dropped; the source must resend it.
- FLUSH: in_ready = 0, lb_en = 1, lb_din = 0 for exactly LINE_WORDS cycles, then CLEAR.
- CLEAR: lb_rst = 1 for exactly one cycle and all counters reset. frame_done pulses in the same cycle if entered from FLUSH. Next state is IDLE. in_ready = 0 in CLEAR.
- Windows and borders:
  - Each lb_valid in RUN/FLUSH advances out_x/out_y in raster order; win_x = out_x and win_y = out_y (register outputs, stable during the valid cycle).
  - bdr_top = (win_y == 0), bdr_bot = (win_y == FRAME_LINES-1), bdr_left = (win_x == 0), bdr_right = (win_x == LINE_WORDS-1). All flags are gated by win_valid.
  - lb_valid in IDLE/CLEAR is ignored and win_valid = 0.
- Invariant: a normal frame has exactly LINE_WORDS*(FRAME_LINES+1) lb_en cycles and yields exactly LINE_WORDS*FRAME_LINES win_valid cycles. The last one is (LINE_WORDS-1, FRAME_LINES-1), on the final FLUSH-driven output.
- Throughput: back-to-back frames lose LINE_WORDS+1 cycles (FLUSH + CLEAR). An SOF arriving in FLUSH or CLEAR is back-pressured (in_ready = 0) and accepted from IDLE.
- Counter widths: $clog2 of the bound, compared against bound-1. LINE_WORDS that are not a power of two must wrap correctly.

Decomposition:
- The shared package holds the state encoding constants (IDLE/RUN/FLUSH/CLEAR) and the X_W/Y_W width localparam functions; the window/convolution blocks reuse them.
- One natural sub-module is win_coord_tracker: the out_x/out_y counters plus border flags, reused by the 5x5 variant.
- The FSM and input counters stay in line_buffer_ctrl.

Test Plan:
- Basic frame (LINE_WORDS=4, FRAME_LINES=3): continuous 12 pixels with SOF on the first -> 16 lb_en cycles (last 4 with lb_din = 0), 12 win_valid with (x,y) from (0,0) to (3,2), bdr_top on the first 4, bdr_bot on the last 4, frame_done once, lb_rst once.
- Stalls: same frame with in_valid toggling 1010... -> identical lb_en/lb_din sequence when stall cycles are removed, identical coordinates, lb_en never high on a stall cycle.
- Mid-frame SOF: SOF at pixel 6 -> that pixel is not written, sof_err = 1 for 1 cycle, no flush, lb_rst pulse, no frame_done. The following SOF starts a clean frame with a correct 12-window output.
- Back-to-back frames: SOF presented immediately after the last pixel -> in_ready = 0 for 5 cycles (4 FLUSH + 1 CLEAR), SOF accepted in IDLE, second frame coordinates restart at (0,0).
- Pre-SOF garbage: 3 pixels without SOF in IDLE -> dropped, no lb_en, no win_valid.
- Reset mid-FLUSH: assert rst -> all outputs 0 immediately (async), state IDLE, and the next frame is correct.
